// File: rtl/reg_wb_queue_pkg.sv
// Shared register-bank types: address/data widths and the queued writeback entry.
package reg_wb_queue_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int REG_EW = REG_AW + REG_DW;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/reg_wb_queue_if.sv
// Writeback-queue bus: pipeline request side, bank write port, bypass lookups and occupancy.
interface reg_wb_queue_if #(
  parameter int DEPTH = 4
);
  import reg_wb_queue_pkg::*;

  logic                         wb_valid;
  logic                         wb_ready;
  logic [REG_AW-1:0]            wb_addr;
  logic [REG_DW-1:0]            wb_data;
  logic                         drain_en;
  logic [REG_AW-1:0]            waddr;
  logic [REG_DW-1:0]            din;
  logic                         regwrite;
  logic [REG_AW-1:0]            q_raddr1;
  logic [REG_AW-1:0]            q_raddr2;
  logic                         byp_hit1;
  logic [REG_DW-1:0]            byp_data1;
  logic                         byp_hit2;
  logic [REG_DW-1:0]            byp_data2;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output wb_valid, wb_addr, wb_data, drain_en, q_raddr1, q_raddr2,
    input  wb_ready, waddr, din, regwrite, byp_hit1, byp_data1,
    input  byp_hit2, byp_data2, count
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, drain_en, q_raddr1, q_raddr2,
    output wb_ready, waddr, din, regwrite, byp_hit1, byp_data1,
    output byp_hit2, byp_data2, count
  );
endinterface

// File: rtl/reg_wb_queue_match.sv
// Bypass lookup over the queued entries: hit if any valid entry matches, data from the youngest.
module reg_wb_queue_match
  import reg_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wbq_entry_t [DEPTH-1:0]       entries_i,
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [$clog2(DEPTH)-1:0]     head_i,
  input  logic [REG_AW-1:0]            addr_i,
  output logic                         hit_o,
  output logic [REG_DW-1:0]            data_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx_s;
  logic          match_s;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit_o   = 1'b0;
    data_o  = {REG_DW{1'b0}};
    idx_s   = head_i;
    match_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s   = head_i + PW'(k);
      match_s = valid_i[idx_s] && (entries_i[idx_s].addr == addr_i);
      hit_o   = hit_o | match_s;
      data_o  = match_s ? entries_i[idx_s].data : data_o;
    end
  end
endmodule

// File: rtl/reg_wb_queue.sv
// In-order writeback queue in front of the register bank, with two bypass lookup ports.
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  reg_wb_queue_if.slave bus
);
  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wbq_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  wbq_entry_t             out_q, out_d, head_nxt_s;
  logic                   enq_s, deq_s;
  logic [DEPTH-1:0]       valid_s;
  logic [PW-1:0]          age_s;

  assign enq_s = bus.wb_valid && (count_q != FULL_CNT);
  assign deq_s = (count_q != {CW{1'b0}}) && bus.drain_en;

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    valid_s = {DEPTH{1'b0}};
    age_s   = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      age_s      = PW'(i) - head_q;
      valid_s[i] = ({1'b0, age_s} < count_q);
    end
  end

  // Pointer/count update; the bank port registers next cycle's head so an entry
  // accepted at an edge is presented immediately after it.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    head_nxt_s = mem_q[head_q];
    out_d      = out_q;
    if (deq_s) head_d = head_q + PW'(1);
    else       head_d = head_q;
    if (enq_s) tail_d = tail_q + PW'(1);
    else       tail_d = tail_q;
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (enq_s && (tail_q == head_d)) head_nxt_s = {bus.wb_addr, bus.wb_data};
    else                             head_nxt_s = mem_q[head_d];
    if (count_d != {CW{1'b0}}) out_d = head_nxt_s;
    else                       out_d = out_q;
  end

  // State registers and entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      out_q   <= {REG_EW{1'b0}};
      mem_q   <= {(DEPTH*REG_EW){1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      out_q   <= out_d;
      if (enq_s) mem_q[tail_q] <= {bus.wb_addr, bus.wb_data};
    end
  end

  assign bus.wb_ready = (count_q != FULL_CNT);
  assign bus.regwrite = deq_s;
  assign bus.waddr    = out_q.addr;
  assign bus.din      = out_q.data;
  assign bus.count    = count_q;

  reg_wb_queue_match #(.DEPTH(DEPTH)) u_match1 (
    .entries_i (mem_q),
    .valid_i   (valid_s),
    .head_i    (head_q),
    .addr_i    (bus.q_raddr1),
    .hit_o     (bus.byp_hit1),
    .data_o    (bus.byp_data1)
  );

  reg_wb_queue_match #(.DEPTH(DEPTH)) u_match2 (
    .entries_i (mem_q),
    .valid_i   (valid_s),
    .head_i    (head_q),
    .addr_i    (bus.q_raddr2),
    .hit_o     (bus.byp_hit2),
    .data_o    (bus.byp_data2)
  );
endmodule
